// File: rtl/astra_bus_pkg.sv
// astra_bus_pkg: shared bus encodings and arbiter types for the system RAM path.
//   RW_READ / RW_WRITE : bus direction encoding (1 = read, 0 = write)
//   CNT_W              : width of the DMA burst counter (DMA_BURST_MAX <= 15)
//   arb_state_t        : arbiter FSM states (IDLE / DMA / YIELD)
//   rd_owner_t         : owner of the read data returning this cycle
package astra_bus_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DMA   = 2'd1,
    ST_YIELD = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/mem_arb_fsm.sv
// mem_arb_fsm: ownership FSM for the shared RAM port.
// Holds the state register and (when ARB_BURST_LIMIT_EN is defined) the DMA
// burst counter; produces the per-cycle grants combinationally from the
// registered state and dma_req.
//   clk, reset  : clock, asynchronous active-high reset
//   dma_req     : DMA request level
//   grant_cpu   : CPU owns the RAM this cycle
//   grant_dma   : DMA owns the RAM this cycle
// Optional feature macro: ARB_BURST_LIMIT_EN (bounded DMA bursts + YIELD state).
module mem_arb_fsm
  import astra_bus_pkg::*;
#(
  parameter int unsigned DMA_BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  output logic grant_cpu,
  output logic grant_dma
);

  arb_state_t state;

`ifdef ARB_BURST_LIMIT_EN
  // Count value at which the current grant is the last one of the burst.
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(DMA_BURST_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // The DMA_BURST_MAX-th grant moves straight into YIELD, so YIELD itself is
  // the single forced CPU cycle: MAX grants out of every MAX+1 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dma_req) begin
            cnt   <= CNT_W'(1);
            state <= (BURST_LAST == '0) ? ST_YIELD : ST_DMA;
          end
        end
        ST_DMA: begin
          if (!dma_req) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == BURST_LAST) begin
            cnt   <= '0;
            state <= ST_YIELD;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        ST_YIELD: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // YIELD always hands the cycle to the CPU.
  always_comb begin
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    if (!reset) begin
      grant_dma = dma_req && (state != ST_YIELD);
      grant_cpu = !grant_dma;
    end
  end
`else
  // Unbounded: DMA keeps the bus for as long as it requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (dma_req)  state <= ST_DMA;
        ST_DMA:  if (!dma_req) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    if (!reset) begin
      grant_dma = dma_req;
      grant_cpu = !dma_req;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port system RAM between the 6502 core and a
// DMA requester. One requester is granted per cycle; the granted side's bus is
// muxed onto the RAM, and read data is steered back one cycle later.
//   clk, reset                    : clock, asynchronous active-high reset
//   cpu_RW, cpu_AD, cpu_D_out     : CPU bus (CPU requests every cycle)
//   cpu_D_in, cpu_RDY             : CPU read data, CPU granted this cycle
//   dma_req, dma_RW, dma_A, dma_D_out : DMA request and bus
//   dma_ack, dma_rvalid, dma_D_in : DMA granted, read data valid, read data
//   ram_RW, ram_A, ram_D_in       : RAM bus driven to the RAM
//   ram_D_out                     : RAM registered read data
// Optional feature macro: ARB_BURST_LIMIT_EN (bounded DMA bursts).
module mem_arbiter
  import astra_bus_pkg::*;
#(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned DMA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_RW,
  input  logic [15:0]       cpu_AD,
  input  logic [DATA_W-1:0] cpu_D_out,
  output logic [DATA_W-1:0] cpu_D_in,
  output logic              cpu_RDY,
  input  logic              dma_req,
  input  logic              dma_RW,
  input  logic [ADDR_W-1:0] dma_A,
  input  logic [DATA_W-1:0] dma_D_out,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_D_in,
  output logic              ram_RW,
  output logic [ADDR_W-1:0] ram_A,
  output logic [DATA_W-1:0] ram_D_in,
  input  logic [DATA_W-1:0] ram_D_out
);

  logic              grant_cpu;
  logic              grant_dma;
  rd_owner_t         rd_owner;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dma_hold;

  // Upper CPU address bits alias onto the RAM and are ignored.
  logic unused_cpu_ad;
  assign unused_cpu_ad = ^cpu_AD[15:ADDR_W];

  mem_arb_fsm #(
    .DMA_BURST_MAX(DMA_BURST_MAX)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .dma_req  (dma_req),
    .grant_cpu(grant_cpu),
    .grant_dma(grant_dma)
  );

  assign cpu_RDY = grant_cpu;
  assign dma_ack = grant_dma;

  // RAM bus mux; idles as a read of address 0 when nobody is granted (reset).
  always_comb begin
    ram_RW   = RW_READ;
    ram_A    = '0;
    ram_D_in = '0;
    if (grant_dma) begin
      ram_RW   = dma_RW;
      ram_A    = dma_A;
      ram_D_in = dma_D_out;
    end else if (grant_cpu) begin
      ram_RW   = cpu_RW;
      ram_A    = cpu_AD[ADDR_W-1:0];
      ram_D_in = cpu_D_out;
    end
  end

  // Tag the side whose read was granted; its data arrives next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
    end else if (grant_dma && (dma_RW == RW_READ)) begin
      rd_owner <= OWN_DMA;
    end else if (grant_cpu && (cpu_RW == RW_READ)) begin
      rd_owner <= OWN_CPU;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // Remember the last returned value per side so each output holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold <= '0;
      dma_hold <= '0;
    end else begin
      if (rd_owner == OWN_CPU) cpu_hold <= ram_D_out;
      if (rd_owner == OWN_DMA) dma_hold <= ram_D_out;
    end
  end

  assign cpu_D_in   = (rd_owner == OWN_CPU) ? ram_D_out : cpu_hold;
  assign dma_D_in   = (rd_owner == OWN_DMA) ? ram_D_out : dma_hold;
  assign dma_rvalid = (rd_owner == OWN_DMA);

endmodule
